// File: rtl/ok_btpipe_pkg.sv
// Shared definitions for the block-throttled pipe endpoints.
package ok_btpipe_pkg;

  // Legal endpoint address window for block-throttled output pipes
  localparam logic [7:0] BTPIPEOUT_MIN = 8'hA0;
  localparam logic [7:0] BTPIPEOUT_MAX = 8'hBF;

  // User source returns data this many cycles after ep_read
  localparam int EP_READ_LATENCY = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } bt_state_e;

endpackage

// File: rtl/ok_prefetch_fifo.sv
// Small show-ahead FIFO: head always presents the oldest stored word.
module ok_prefetch_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CW-1:0]    count_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_push = push_i & ~full;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_q];
  assign count_o = count_q;

  // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of two
  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (flush_i) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end
  end

  // Control state: pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  // Storage array carries data only, so it has no reset
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/ok_btpipe_out_prefetch.sv
// Block-throttled output pipe endpoint with a prefetch FIFO in front of the user source.
module ok_btpipe_out_prefetch
  import ok_btpipe_pkg::*;
#(
  parameter logic [7:0] EP_ADDR   = 8'hA0,
  parameter int         WIDTH     = 16,
  parameter int         BLOCK_LEN = 256,
  parameter int         DEPTH     = 4
) (
  input  logic             ti_clock,
  input  logic             ti_reset,
  input  logic [7:0]       ti_addr,
  input  logic             ti_blockstrobe,
  input  logic             ti_read,
  output logic [WIDTH-1:0] ti_dataout,
  output logic             ti_ready,
  input  logic             ep_ready,
  output logic             ep_blockstrobe,
  output logic             ep_read,
  input  logic [WIDTH-1:0] ep_datain,
  output logic             underrun
);

  localparam int BW  = $clog2(BLOCK_LEN) + 1;
  localparam int FCW = $clog2(DEPTH) + 1;

  if (EP_ADDR < BTPIPEOUT_MIN || EP_ADDR > BTPIPEOUT_MAX) begin : g_bad_addr
    $fatal(1, "ok_btpipe_out_prefetch: EP_ADDR outside 0xA0..0xBF");
  end
  if (BLOCK_LEN < 2 || BLOCK_LEN > 1024 || (BLOCK_LEN & (BLOCK_LEN - 1)) != 0) begin : g_bad_len
    $fatal(1, "ok_btpipe_out_prefetch: BLOCK_LEN must be a power of two in 2..1024");
  end
  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "ok_btpipe_out_prefetch: DEPTH must be a power of two in 2..16");
  end

  bt_state_e        state_q;
  logic [BW-1:0]    issued_q, consumed_q;
  logic             ep_read_q, in_flight_q, ep_blockstrobe_q, underrun_q;

  logic             sel, stream, host_rd, pop, blk_start, block_end, push;
  logic             credit, ep_read_d, underrun_d;
  logic [WIDTH-1:0] fifo_head;
  logic [FCW-1:0]   fifo_count;
  logic             fifo_empty;

  assign sel       = (ti_addr == EP_ADDR);
  assign stream    = (state_q == STREAM);
  assign host_rd   = sel & ti_read;
  assign pop       = host_rd & stream;
  assign blk_start = sel & ti_blockstrobe & ep_ready & (state_q == IDLE);
  assign block_end = pop & (consumed_q == BW'(BLOCK_LEN - 1));
  // A word landing on the block-end edge belongs to an underrun block and is dropped
  assign push      = in_flight_q & stream & ~block_end;

  // Words requested but not yet in the FIFO still hold a slot
  assign credit    = (int'(fifo_count) + int'(ep_read_q) + int'(in_flight_q)) < DEPTH;
  assign ep_read_d = stream & ~block_end & credit & (issued_q < BW'(BLOCK_LEN));

  assign underrun_d = underrun_q
                    | (pop & fifo_empty)
                    | (host_rd & ~stream)
                    | (sel & ti_blockstrobe & (stream | ~ep_ready));

  assign ti_ready       = sel & ep_ready & (state_q == IDLE);
  assign ti_dataout     = (sel && !fifo_empty) ? fifo_head : '0;
  assign ep_read        = ep_read_q;
  assign ep_blockstrobe = ep_blockstrobe_q;
  assign underrun       = underrun_q;

  ok_prefetch_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (ti_clock),
    .rst_i   (ti_reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (block_end),
    .din_i   (ep_datain),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  // Block FSM with issue/consume counters and registered user-side strobes
  always_ff @(posedge ti_clock or posedge ti_reset) begin
    if (ti_reset) begin
      state_q          <= IDLE;
      issued_q         <= '0;
      consumed_q       <= '0;
      ep_read_q        <= 1'b0;
      in_flight_q      <= 1'b0;
      ep_blockstrobe_q <= 1'b0;
      underrun_q       <= 1'b0;
    end else begin
      ep_blockstrobe_q <= blk_start;
      ep_read_q        <= ep_read_d;
      in_flight_q      <= ep_read_q;
      underrun_q       <= underrun_d;
      case (state_q)
        IDLE: begin
          if (blk_start) begin
            state_q    <= STREAM;
            issued_q   <= '0;
            consumed_q <= '0;
          end
        end
        STREAM: begin
          if (ep_read_d) issued_q   <= issued_q + BW'(1);
          if (pop)       consumed_q <= consumed_q + BW'(1);
          if (block_end) state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ok_btpipe_out_prefetch.sv
// Directed bench for ok_btpipe_out_prefetch (EP 0xA0, 8-word blocks, 4-deep prefetch).
module tb_ok_btpipe_out_prefetch;

  localparam logic [7:0] EPA = 8'hA0;
  localparam int         BL  = 8;
  localparam int         DP  = 4;

  logic        clk = 1'b0;
  logic        ti_reset;
  logic [7:0]  ti_addr;
  logic        ti_blockstrobe;
  logic        ti_read;
  logic [15:0] ti_dataout;
  logic        ti_ready;
  logic        ep_ready;
  logic        ep_blockstrobe;
  logic        ep_read;
  logic [15:0] ep_datain = 16'h0000;
  logic        underrun;

  int n_tests = 0;
  int n_fail  = 0;

  // Source model and pulse monitors
  logic [15:0] src = 16'h0100;
  int n_epread = 0;
  int n_bstb   = 0;

  // Per-block bookkeeping for occupancy tracking
  int rd0, pops, occ_max;

  always #5 clk = ~clk;

  ok_btpipe_out_prefetch #(
    .EP_ADDR   (EPA),
    .WIDTH     (16),
    .BLOCK_LEN (BL),
    .DEPTH     (DP)
  ) dut (
    .ti_clock       (clk),
    .ti_reset       (ti_reset),
    .ti_addr        (ti_addr),
    .ti_blockstrobe (ti_blockstrobe),
    .ti_read        (ti_read),
    .ti_dataout     (ti_dataout),
    .ti_ready       (ti_ready),
    .ep_ready       (ep_ready),
    .ep_blockstrobe (ep_blockstrobe),
    .ep_read        (ep_read),
    .ep_datain      (ep_datain),
    .underrun       (underrun)
  );

  // User source: one-cycle read latency, incrementing words
  always @(posedge clk) begin
    if (ep_read) begin
      ep_datain <= src;
      src       <= src + 16'h0001;
      n_epread  <= n_epread + 1;
    end
    if (ep_blockstrobe) n_bstb <= n_bstb + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock, then track words held by the endpoint (FIFO + requested)
  task automatic step();
    int occ;
    logic rd;
    rd = ti_read && (ti_addr == EPA);
    @(posedge clk);
    #1;
    if (rd) pops++;
    occ = (n_epread - rd0) + int'(ep_read) - pops;
    if (occ > occ_max) occ_max = occ;
  endtask

  task automatic do_reset();
    ti_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ti_reset = 1'b0;
    step();
  endtask

  task automatic start_block(output logic [15:0] base, output int bs0);
    base    = src;
    bs0     = n_bstb;
    rd0     = n_epread;
    pops    = 0;
    occ_max = 0;
    ti_addr        = EPA;
    ti_blockstrobe = 1'b1;
    step();
    ti_blockstrobe = 1'b0;
  endtask

  // Full block: wait 3 cycles then read every `gap` cycles, checking data order
  task automatic run_block(input string tag, input int gap, input logic exp_und);
    logic [15:0] base;
    int bs0;
    start_block(base, bs0);
    repeat (3) step();
    for (int k = 0; k < BL; k++) begin
      ti_read = 1'b1;
      #1;
      chk({tag, "_data"}, 32'(ti_dataout), 32'(base + 16'(k)));
      step();
      ti_read = 1'b0;
      repeat (gap - 1) step();
    end
    #1;
    chk({tag, "_idle_ready"}, 32'(ti_ready), 32'd1);
    chk({tag, "_idle_dout"}, 32'(ti_dataout), 32'd0);
    repeat (3) step();
    chk({tag, "_epread_cnt"}, 32'(n_epread - rd0), 32'(BL));
    chk({tag, "_bstb_cnt"}, 32'(n_bstb - bs0), 32'd1);
    chk({tag, "_occ_le_depth"}, 32'(occ_max <= DP), 32'd1);
    chk({tag, "_underrun"}, 32'(underrun), 32'(exp_und));
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic        rdy;
    logic        exp_ready;
    logic [15:0] exp_dout;
  } vec_t;

  initial begin
    vec_t        vecs [6];
    logic [15:0] base;
    int          bs0, ep0;

    vecs[0] = '{addr: 8'hA0, rdy: 1'b0, exp_ready: 1'b0, exp_dout: 16'h0000};
    vecs[1] = '{addr: 8'hA0, rdy: 1'b1, exp_ready: 1'b1, exp_dout: 16'h0000};
    vecs[2] = '{addr: 8'hA1, rdy: 1'b1, exp_ready: 1'b0, exp_dout: 16'h0000};
    vecs[3] = '{addr: 8'hA1, rdy: 1'b0, exp_ready: 1'b0, exp_dout: 16'h0000};
    vecs[4] = '{addr: 8'hBF, rdy: 1'b1, exp_ready: 1'b0, exp_dout: 16'h0000};
    vecs[5] = '{addr: 8'hA0, rdy: 1'b1, exp_ready: 1'b1, exp_dout: 16'h0000};

    ti_reset = 1'b1; ti_addr = EPA; ti_blockstrobe = 1'b0; ti_read = 1'b0; ep_ready = 1'b1;
    rd0 = 0; pops = 0; occ_max = 0;
    do_reset();

    // Reset state
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_epread", 32'(ep_read), 32'd0);
    chk("rst_ready", 32'(ti_ready), 32'd1);

    // Reset mid-STREAM (underrun set first by a read in IDLE)
    ti_read = 1'b1; step(); ti_read = 1'b0;
    chk("idle_read_underrun", 32'(underrun), 32'd1);
    start_block(base, bs0);
    chk("t1_bstb_pulse", 32'(ep_blockstrobe), 32'd1);
    chk("t1_stream_not_ready", 32'(ti_ready), 32'd0);
    step();
    chk("t1_bstb_single", 32'(ep_blockstrobe), 32'd0);
    repeat (2) step();
    chk("t1_dout_head", 32'(ti_dataout), 32'(base));
    chk("t1_epread_active", 32'(ep_read), 32'd1);
    @(negedge clk);
    ti_reset = 1'b1;
    #1;
    chk("t1_rst_epread", 32'(ep_read), 32'd0);
    chk("t1_rst_bstb", 32'(ep_blockstrobe), 32'd0);
    chk("t1_rst_dout", 32'(ti_dataout), 32'd0);
    chk("t1_rst_underrun", 32'(underrun), 32'd0);
    chk("t1_rst_idle", 32'(ti_ready), 32'd1);
    @(negedge clk);
    ti_reset = 1'b0;
    step();

    // Combinational ready / output mux vectors in IDLE
    for (int i = 0; i < 6; i++) begin
      ti_addr  = vecs[i].addr;
      ep_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_ready", i), 32'(ti_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_dout", i), 32'(ti_dataout), 32'(vecs[i].exp_dout));
    end
    ti_addr = EPA; ep_ready = 1'b1;
    step();

    // Full block back-to-back, then throttled block
    run_block("t3_full", 1, 1'b0);
    run_block("t5_throttle", 3, 1'b0);

    // Stray traffic for another endpoint
    ep0 = n_epread; bs0 = n_bstb;
    ti_addr = 8'hA1; ti_blockstrobe = 1'b1; ti_read = 1'b1;
    step();
    ti_blockstrobe = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t6_dout", 32'(ti_dataout), 32'd0);
      step();
    end
    ti_read = 1'b0;
    step();
    chk("t6_no_epread", 32'(n_epread - ep0), 32'd0);
    chk("t6_no_bstb", 32'(n_bstb - bs0), 32'd0);
    chk("t6_underrun", 32'(underrun), 32'd0);

    // Strobe while the source is not ready: ignored but flagged
    ti_addr = EPA; ep_ready = 1'b0; ti_blockstrobe = 1'b1;
    step();
    ti_blockstrobe = 1'b0;
    chk("t7_no_bstb", 32'(ep_blockstrobe), 32'd0);
    chk("t7_underrun", 32'(underrun), 32'd1);
    repeat (3) step();
    chk("t7_no_epread", 32'(n_epread - ep0), 32'd0);
    ep_ready = 1'b1;
    #1;
    chk("t7_still_idle", 32'(ti_ready), 32'd1);

    // Underrun: read right after the strobe, then finish the block
    do_reset();
    start_block(base, bs0);
    ti_read = 1'b1;
    #1;
    chk("t4_empty_dout", 32'(ti_dataout), 32'd0);
    step();
    ti_read = 1'b0;
    chk("t4_underrun", 32'(underrun), 32'd1);
    repeat (2) step();
    for (int k = 0; k < BL - 1; k++) begin
      ti_read = 1'b1;
      #1;
      chk("t4_data", 32'(ti_dataout), 32'(base + 16'(k)));
      step();
    end
    ti_read = 1'b0;
    #1;
    chk("t4_idle_ready", 32'(ti_ready), 32'd1);
    chk("t4_flushed_dout", 32'(ti_dataout), 32'd0);
    repeat (3) step();
    chk("t4_epread_cnt", 32'(n_epread - rd0), 32'(BL));
    chk("t4_flushed_dout2", 32'(ti_dataout), 32'd0);

    // Following block must not see the flushed leftover word
    run_block("t4_next", 1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Absolute time bound
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, tests %0d", n_tests);
    $fatal(1, "timeout");
  end

endmodule
